// File: rtl/redundancy_pkg.sv
// Shared constants, drainer state encoding and lane-slice helper for the redundancy datapath.
package redundancy_pkg;

    localparam int LANES  = 128;
    localparam int PSUM_W = 8;
    localparam int IDX_W  = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // LSB position of lane `lane` inside the packed prefix-sum bus
    function automatic int lane_lsb(input int lane);
        return lane * PSUM_W;
    endfunction

endpackage

// File: rtl/lane_index_select.sv
// Finds the lane whose mask bit is set and whose inclusive prefix sum equals target.
// Purely combinational; with a consistent prefix sum at most one lane can match.
module lane_index_select
    import redundancy_pkg::*;
(
    input  logic [LANES-1:0]        mask,
    input  logic [LANES*PSUM_W-1:0] psum,
    input  logic [PSUM_W:0]         target,
    output logic [IDX_W-1:0]        idx,
    output logic                    hit
);

    // OR-reduction of matching lane numbers acts as the one-hot encoder
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i] && ({1'b0, psum[lane_lsb(i) +: PSUM_W]} == target)) begin
                idx = idx | IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mask_index_drainer.sv
// Drains set-bit indices of a mask in ascending order, OUT_LANES per beat; first beat 1 cycle after capture.
// Stalled beats hold stable; a new vector is taken in the same cycle the last beat is accepted.
// Optional MASK_INDEX_DRAINER_SKIP_EMPTY_EN: vectors with no set bits are accepted and dropped.
module mask_index_drainer
    import redundancy_pkg::*;
#(
    parameter int OUT_LANES = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES-1:0]               mask,
    input  logic [LANES*PSUM_W-1:0]        psum,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_LANES*IDX_W-1:0]     out_idx,
    output logic [$clog2(OUT_LANES+1)-1:0] out_count,
    output logic                           out_last
);

    localparam int                CNT_W    = $clog2(OUT_LANES + 1);
    localparam logic [PSUM_W-1:0] OUT_STEP = PSUM_W'(OUT_LANES);

    drain_state_t              state;
    logic [LANES-1:0]          mask_q;
    logic [LANES*PSUM_W-1:0]   psum_q;
    logic [PSUM_W-1:0]         total_q;
    logic [PSUM_W-1:0]         base_q;

    logic [PSUM_W-1:0]         in_total;
    logic                      in_empty;
    logic                      last_raw;
    logic [PSUM_W-1:0]         remaining;
    logic                      capture;

    assign in_total = psum[lane_lsb(LANES-1) +: PSUM_W];

`ifdef MASK_INDEX_DRAINER_SKIP_EMPTY_EN
    assign in_empty = (in_total == '0);
`else
    assign in_empty = 1'b0;
`endif

    // Compared one bit wider so base near LANES cannot wrap past total
    assign last_raw  = ({1'b0, base_q} + {1'b0, OUT_STEP}) >= {1'b0, total_q};
    assign remaining = total_q - base_q;

    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && last_raw;
    assign in_ready  = (state == IDLE) || ((state == DRAIN) && last_raw && out_ready);
    assign capture   = in_valid && in_ready;

    always_comb begin
        out_count = '0;
        if (total_q > base_q) begin
            out_count = (remaining >= OUT_STEP) ? CNT_W'(OUT_LANES) : CNT_W'(remaining);
        end
    end

    for (genvar k = 0; k < OUT_LANES; k++) begin : g_slot
        logic [PSUM_W:0]    target;
        logic [IDX_W-1:0]   idx;
        logic               hit;

        assign target = {1'b0, base_q} + (PSUM_W+1)'(k + 1);

        lane_index_select u_sel (
            .mask   (mask_q),
            .psum   (psum_q),
            .target (target),
            .idx    (idx),
            .hit    (hit)
        );

        assign out_idx[k*IDX_W +: IDX_W] = hit ? idx : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            mask_q  <= '0;
            psum_q  <= '0;
            total_q <= '0;
            base_q  <= '0;
        end else if (capture) begin
            mask_q  <= mask;
            psum_q  <= psum;
            total_q <= in_total;
            base_q  <= '0;
            state   <= in_empty ? IDLE : DRAIN;
        end else if ((state == DRAIN) && out_ready) begin
            if (last_raw) begin
                state <= IDLE;
            end else begin
                base_q <= base_q + OUT_STEP;
            end
        end
    end

endmodule

// File: tb/tb_mask_index_drainer.sv
// Directed-vector bench for mask_index_drainer; inputs change and outputs are sampled on the falling edge.
module tb_mask_index_drainer;
    import redundancy_pkg::*;

    localparam int OL = 8;
    localparam int CW = $clog2(OL + 1);

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        mask;
    logic [LANES*PSUM_W-1:0] psum;
    logic                    out_valid;
    logic                    out_ready;
    logic [OL*IDX_W-1:0]     out_idx;
    logic [CW-1:0]           out_count;
    logic                    out_last;

    int total_n = 0;
    int bad_n   = 0;

    mask_index_drainer #(.OUT_LANES(OL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mask      (mask),
        .psum      (psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*PSUM_W-1:0] make_psum(input logic [LANES-1:0] m);
        logic [LANES*PSUM_W-1:0] p;
        int acc;
        p = '0;
        acc = 0;
        for (int i = 0; i < LANES; i++) begin
            acc += int'(m[i]);
            p[i*PSUM_W +: PSUM_W] = PSUM_W'(acc);
        end
        return p;
    endfunction

    function automatic logic [OL*IDX_W-1:0] pack_seq(input int start, input int n);
        logic [OL*IDX_W-1:0] v;
        v = '0;
        for (int k = 0; k < OL; k++)
            if (k < n) v[k*IDX_W +: IDX_W] = IDX_W'(start + k);
        return v;
    endfunction

    function automatic logic [OL*IDX_W-1:0] pack8(input int s0, s1, s2, s3, s4, s5, s6, s7);
        return {IDX_W'(s7), IDX_W'(s6), IDX_W'(s5), IDX_W'(s4),
                IDX_W'(s3), IDX_W'(s2), IDX_W'(s1), IDX_W'(s0)};
    endfunction

    task automatic load_vec(input logic [LANES-1:0] m);
        in_valid = 1'b1;
        mask     = m;
        psum     = make_psum(m);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mask = '0; psum = '0;
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 ||
            out_count !== '0 || out_idx !== '0) begin
            bad_n++;
            $display("FAIL reset: valid=%b ready=%b last=%b count=%0d idx=%h required 0 1 0 0 0",
                     out_valid, in_ready, out_last, out_count, out_idx);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        load_vec(128'h0001_0000_0000_0000_0000_0000_0000_8421);
        total_n++;
        if (out_valid !== 1'b0) begin
            bad_n++; $display("FAIL single_pre_valid: got %b required 0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total_n++;
        if (out_valid !== 1'b1 || out_count !== CW'(5) || out_last !== 1'b1 ||
            out_idx !== pack8(0, 5, 10, 15, 112, 0, 0, 0)) begin
            bad_n++;
            $display("FAIL single_beat: valid=%b count=%0d last=%b idx=%h required 1 5 1 %h",
                     out_valid, out_count, out_last, out_idx, pack8(0, 5, 10, 15, 112, 0, 0, 0));
        end
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad_n++; $display("FAIL single_idle: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        load_vec('1);
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total_n++;
            if (out_valid !== 1'b1 || out_count !== CW'(8) || out_last !== (b == 15) ||
                out_idx !== pack_seq(b * 8, 8)) begin
                bad_n++;
                $display("FAIL full_beat%0d: valid=%b count=%0d last=%b idx=%h required 1 8 %b %h",
                         b, out_valid, out_count, out_last, out_idx, (b == 15), pack_seq(b * 8, 8));
            end
        end
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0) begin
            bad_n++; $display("FAIL full_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        load_vec(128'h1FF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total_n++;
            if (out_valid !== 1'b1 || out_count !== CW'(8) || out_last !== 1'b0 ||
                out_idx !== pack_seq(0, 8) || in_ready !== 1'b0) begin
                bad_n++;
                $display("FAIL stall_hold%0d: valid=%b count=%0d last=%b idx=%h ready=%b required 1 8 0 %h 0",
                         c, out_valid, out_count, out_last, out_idx, in_ready, pack_seq(0, 8));
            end
            out_ready = (c == 2);
        end
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b1 || out_count !== CW'(1) || out_last !== 1'b1 ||
            out_idx !== pack_seq(8, 1)) begin
            bad_n++;
            $display("FAIL stall_beat2: valid=%b count=%0d last=%b idx=%h required 1 1 1 %h",
                     out_valid, out_count, out_last, out_idx, pack_seq(8, 1));
        end
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0) begin
            bad_n++; $display("FAIL stall_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        load_vec(128'h3FF);
        @(negedge clk);
        load_vec((128'h1 << 100) | 128'h8);
        total_n++;
        if (out_count !== CW'(8) || out_last !== 1'b0 || out_idx !== pack_seq(0, 8) || in_ready !== 1'b0) begin
            bad_n++;
            $display("FAIL b2b_a1: count=%0d last=%b idx=%h ready=%b required 8 0 %h 0",
                     out_count, out_last, out_idx, in_ready, pack_seq(0, 8));
        end
        @(negedge clk);
        total_n++;
        if (out_count !== CW'(2) || out_last !== 1'b1 || out_idx !== pack_seq(8, 2) || in_ready !== 1'b1) begin
            bad_n++;
            $display("FAIL b2b_a2: count=%0d last=%b idx=%h ready=%b required 2 1 %h 1",
                     out_count, out_last, out_idx, in_ready, pack_seq(8, 2));
        end
        @(negedge clk);
        in_valid = 1'b0;
        total_n++;
        if (out_valid !== 1'b1 || out_count !== CW'(2) || out_last !== 1'b1 ||
            out_idx !== pack8(3, 100, 0, 0, 0, 0, 0, 0)) begin
            bad_n++;
            $display("FAIL b2b_b: valid=%b count=%0d last=%b idx=%h required 1 2 1 %h",
                     out_valid, out_count, out_last, out_idx, pack8(3, 100, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0) begin
            bad_n++; $display("FAIL b2b_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_empty();
        out_ready = 1'b1;
        load_vec('0);
        @(negedge clk);
        in_valid = 1'b0;
        total_n++;
`ifdef MASK_INDEX_DRAINER_SKIP_EMPTY_EN
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad_n++; $display("FAIL empty_skip: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
`else
        if (out_valid !== 1'b1 || out_count !== '0 || out_last !== 1'b1 || out_idx !== '0) begin
            bad_n++;
            $display("FAIL empty_beat: valid=%b count=%0d last=%b idx=%h required 1 0 1 0",
                     out_valid, out_count, out_last, out_idx);
        end
`endif
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad_n++; $display("FAIL empty_end: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        load_vec('1);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        total_n++;
        if (out_valid !== 1'b1 || out_idx !== pack_seq(16, 8)) begin
            bad_n++;
            $display("FAIL rstmid_beat3: valid=%b idx=%h required 1 %h", out_valid, out_idx, pack_seq(16, 8));
        end
        reset_n = 1'b0;
        #1;
        total_n++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 ||
            out_count !== '0 || out_idx !== '0) begin
            bad_n++;
            $display("FAIL rstmid_async: valid=%b ready=%b last=%b count=%0d idx=%h required 0 1 0 0 0",
                     out_valid, in_ready, out_last, out_count, out_idx);
        end
        #1;
        reset_n = 1'b1;
        load_vec(128'h8421);
        @(negedge clk);
        in_valid = 1'b0;
        total_n++;
        if (out_valid !== 1'b1 || out_count !== CW'(4) || out_last !== 1'b1 ||
            out_idx !== pack8(0, 5, 10, 15, 0, 0, 0, 0)) begin
            bad_n++;
            $display("FAIL rstmid_next: valid=%b count=%0d last=%b idx=%h required 1 4 1 %h",
                     out_valid, out_count, out_last, out_idx, pack8(0, 5, 10, 15, 0, 0, 0, 0));
        end
        @(negedge clk);
        total_n++;
        if (out_valid !== 1'b0) begin
            bad_n++; $display("FAIL rstmid_end: valid=%b required 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_stall();
        test_back_to_back();
        test_empty();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
